// File: rtl/hikizan_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents:
//   state_t : controller states (idle, running, result pulse)
//   clog2   : ceiling log2, used to size the bit counter
package hikizan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns the number of bits needed to hold values 0..value-1.
    // The result is never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_tasizan.sv
// One-bit full adder, the only arithmetic cell in the serial datapath.
// Ports:
//   x, y  : addend bits
//   cin   : carry in
//   sum   : sum bit
//   cout  : carry out
module full_tasizan (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_hikizan.sv
// Bit-serial subtractor d = a - b. Each cycle handles one bit, LSB first,
// through a single full adder that adds a to the inverted b, with the carry
// preset to 1 for the two's-complement increment.
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : operation request, sampled only while idle
//   a, b   : minuend and subtrahend, captured on the accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse once the result is valid
//   d      : a - b modulo 2^WIDTH, updated only on completion
//   borrow : set when a < b, unsigned
//   ovf    : signed overflow of a - b
module serial_hikizan
    import hikizan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf
);

    // Counter reaches WIDTH on the final step, so it needs room for WIDTH.
    localparam int CW = clog2(WIDTH + 1);

    state_t state;
    state_t state_next;

    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sum;
    logic             cout;
    logic [WIDTH-1:0] res_next;

    full_tasizan u_fa (
        .x    (a_sh[0]),
        .y    (~b_sh[0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Partial result: each new sum bit enters at the MSB end so that after
    // WIDTH steps bit 0 has arrived at the LSB. Only WIDTH-1 earlier bits
    // need storing because the current sum completes the word.
    generate
        if (WIDTH == 1) begin : g_res_single
            assign res_next = sum;
        end else begin : g_res_multi
            logic [WIDTH-2:0] res_sh;

            assign res_next = {sum, res_sh};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_sh <= '0;
                end else if (step) begin
                    res_sh <= res_next[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // On the last step a_sh[0]/b_sh[0] hold the operand sign bits and
    // res_next[WIDTH-1] is the result sign, which is all ovf needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            d      <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            carry <= 1'b1;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CW'(1);
            carry <= cout;
            if (last) begin
                d      <= res_next;
                borrow <= ~cout;
                ovf    <= (a_sh[0] ^ b_sh[0]) & (res_next[WIDTH-1] ^ a_sh[0]);
            end
        end
    end

endmodule

// File: tb/tb_serial_hikizan.sv
// Testbench for serial_hikizan: an 8-bit instance checked every cycle
// against a cycle-count model, plus 1-bit and 32-bit instances checked
// per operation against an arithmetic reference.
module tb_serial_hikizan;

    localparam int W = 8;

    logic         clk;
    logic         rst;

    logic         start;
    logic [7:0]   a;
    logic [7:0]   b;
    logic         busy;
    logic         done;
    logic [7:0]   d;
    logic         borrow;
    logic         ovf;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         busy1;
    logic         done1;
    logic [0:0]   d1;
    logic         borrow1;
    logic         ovf1;

    logic         start32;
    logic [31:0]  a32;
    logic [31:0]  b32;
    logic         busy32;
    logic         done32;
    logic [31:0]  d32;
    logic         borrow32;
    logic         ovf32;

    int total = 0;
    int bad   = 0;

    serial_hikizan #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .borrow(borrow), .ovf(ovf)
    );

    serial_hikizan #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .d(d1), .borrow(borrow1), .ovf(ovf1)
    );

    serial_hikizan #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .d(d32), .borrow(borrow32), .ovf(ovf32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference subtraction for a w-bit word: returns {ovf, borrow, d[31:0]}.
    function automatic logic [33:0] ref_sub(input int w, input longint unsigned av,
                                             input longint unsigned bv);
        longint unsigned mask;
        longint unsigned dv;
        longint sa, sb, diff, hi, lo;
        logic br, ov;
        mask = (64'd1 << w) - 64'd1;
        dv   = (av - bv) & mask;
        br   = (av < bv);
        sa   = longint'(av);
        sb   = longint'(bv);
        if (((av >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
        if (((bv >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
        diff = sa - sb;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        ov   = (diff > hi) || (diff < lo);
        return {ov, br, dv[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of the 8-bit instance: phase counts edges since acceptance.
    int          phase;
    logic [33:0] pend;
    logic [7:0]  exp_d;
    logic        exp_br;
    logic        exp_ov;
    logic        exp_busy;
    logic        exp_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= -1;
            exp_d  <= '0;
            exp_br <= 1'b0;
            exp_ov <= 1'b0;
        end else if (phase < 0) begin
            if (start) begin
                phase <= 0;
                pend  <= ref_sub(W, 64'(a), 64'(b));
            end
        end else if (phase == W - 1) begin
            phase  <= W;
            exp_d  <= pend[7:0];
            exp_br <= pend[32];
            exp_ov <= pend[33];
        end else if (phase == W) begin
            phase <= -1;
        end else begin
            phase <= phase + 1;
        end
    end

    assign exp_busy = (phase >= 0) && (phase < W);
    assign exp_done = (phase == W);

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("busy",   64'(busy),   64'(exp_busy));
            checkOutput("done",   64'(done),   64'(exp_done));
            checkOutput("d",      64'(d),      64'(exp_d));
            checkOutput("borrow", 64'(borrow), 64'(exp_br));
            checkOutput("ovf",    64'(ovf),    64'(exp_ov));
        end
    end

    // Issues one 8-bit operation and waits for done; optionally toggles
    // start randomly while the operation is in flight.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input bit noise, output int lat);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        lat   = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a     = 8'($urandom);
                b     = 8'($urandom);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic runOp(input string name, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
        int lat;
        applyStimulus(av, bv, 1'b0, lat);
        checkOutput({name, "_lat"},    64'(lat),    64'(8));
        checkOutput({name, "_d"},      64'(d),      64'(ed));
        checkOutput({name, "_borrow"}, 64'(borrow), 64'(eb));
        checkOutput({name, "_ovf"},    64'(ovf),    64'(eo));
    endtask

    task automatic runW1(input logic av, input logic bv);
        int lat;
        logic [33:0] r;
        @(negedge clk);
        start1 = 1'b1;
        a1     = av;
        b1     = bv;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        lat    = 0;
        while (!done1 && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = ref_sub(1, 64'(av), 64'(bv));
        checkOutput("w1_lat",    64'(lat),     64'(1));
        checkOutput("w1_busy",   64'(busy1),   64'(0));
        checkOutput("w1_d",      64'(d1),      64'(r[0]));
        checkOutput("w1_borrow", 64'(borrow1), 64'(r[32]));
        checkOutput("w1_ovf",    64'(ovf1),    64'(r[33]));
        @(negedge clk);
    endtask

    task automatic runW32(input logic [31:0] av, input logic [31:0] bv);
        int lat;
        logic [33:0] r;
        @(negedge clk);
        start32 = 1'b1;
        a32     = av;
        b32     = bv;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        lat     = 0;
        while (!done32 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = ref_sub(32, 64'(av), 64'(bv));
        checkOutput("w32_lat",    64'(lat),      64'(32));
        checkOutput("w32_busy",   64'(busy32),   64'(0));
        checkOutput("w32_d",      64'(d32),      64'(r[31:0]));
        checkOutput("w32_borrow", 64'(borrow32), 64'(r[32]));
        checkOutput("w32_ovf",    64'(ovf32),    64'(r[33]));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int cyc;
        int seen;
        int done_cycles[$];

        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        start1  = 1'b0;
        a1      = '0;
        b1      = '0;
        start32 = 1'b0;
        a32     = '0;
        b32     = '0;

        #1;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_d",    64'(d),    64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Hand-computed results.
        runOp("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        runOp("t2a", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        runOp("t2b", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        runOp("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        runOp("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Random operations with start noise while busy.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'b1, lat);
            checkOutput("rand_lat", 64'(lat), 64'(8));
        end

        // Start held high: one operation every WIDTH+2 cycles.
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 45; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) done_cycles.push_back(cyc);
        end
        start = 1'b0;
        checkOutput("cont_count", 64'(done_cycles.size() >= 4), 64'(1));
        for (int i = 1; i < done_cycles.size(); i++) begin
            checkOutput("cont_spacing", 64'(done_cycles[i] - done_cycles[i-1]), 64'(W + 2));
        end
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        runOp("pre_rst", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'h11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy",   64'(busy),   64'(0));
        checkOutput("arst_done",   64'(done),   64'(0));
        checkOutput("arst_d",      64'(d),      64'(0));
        checkOutput("arst_borrow", 64'(borrow), 64'(0));
        checkOutput("arst_ovf",    64'(ovf),    64'(0));
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        checkOutput("arst_no_done", 64'(seen), 64'(0));
        runOp("post_rst", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // Single-bit build, exhaustive.
        for (int i = 0; i < 4; i++) begin
            runW1(1'(i >> 1), 1'(i));
        end

        // 32-bit build, random vectors plus corner values.
        runW32(32'h0000_0000, 32'h0000_0001);
        runW32(32'h8000_0000, 32'h0000_0001);
        runW32(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 1000; i++) begin
            runW32($urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
